// File: rtl/mac_unit_pkg.sv
// Shared constants and width helpers for the multiply-accumulate datapath.
package mac_unit_pkg;

    localparam int DATA_WIDTH_DEF = 4;
    localparam int OUT_WIDTH_DEF  = 2 * DATA_WIDTH_DEF;

    // Full-precision width of a*b + c: a 2N-bit product plus one carry bit.
    function automatic int sum_width(input int data_width);
        return 2 * data_width + 1;
    endfunction

endpackage

// File: rtl/mac_unit_if.sv
// Operand/result bundle between the debug core and the MAC datapath.
interface mac_unit_if
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] b;
    logic [DATA_WIDTH-1:0] c;
    logic [OUT_WIDTH-1:0]  out;

    // Operand source (debug core / testbench).
    modport master (output a, output b, output c, input out);
    // Datapath side.
    modport slave  (input a, input b, input c, output out);
endinterface

// File: rtl/mac_mult.sv
// Unsigned DATA_WIDTH x DATA_WIDTH multiplier, kept separate so it can map to a DSP slice.
module mac_mult #(
    parameter int DATA_WIDTH = 4
) (
    input  logic [DATA_WIDTH-1:0]   a_i,
    input  logic [DATA_WIDTH-1:0]   b_i,
    output logic [2*DATA_WIDTH-1:0] p_o
);
    // Operands widened first so the product is formed at full precision.
    assign p_o = (2*DATA_WIDTH)'(a_i) * (2*DATA_WIDTH)'(b_i);
endmodule

// File: rtl/mac_unit.sv
// Registered unsigned multiply-accumulate: out <= a*b + c, one result per clock.
module mac_unit
    import mac_unit_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DEF,
    parameter int OUT_WIDTH  = OUT_WIDTH_DEF
) (
    input  logic       clk,
    input  logic       reset,
    mac_unit_if.slave  bus
);
    localparam int SUM_W = sum_width(DATA_WIDTH);

    logic [2*DATA_WIDTH-1:0] prod;
    logic [SUM_W-1:0]        sum;
    logic [OUT_WIDTH-1:0]    out_d;
    logic [OUT_WIDTH-1:0]    out_q;

    mac_mult #(.DATA_WIDTH(DATA_WIDTH)) u_mult (
        .a_i (bus.a),
        .b_i (bus.b),
        .p_o (prod)
    );

    // Full-precision sum; the size cast zero-extends for wide outputs and
    // keeps only the low OUT_WIDTH bits (modulo wrap) for narrow ones.
    always_comb begin
        sum   = SUM_W'(prod) + SUM_W'(bus.c);
        out_d = OUT_WIDTH'(sum);
    end

    // Result register with synchronous clear; c is the only addend, no feedback.
    always_ff @(posedge clk) begin
        if (reset) out_q <= '0;
        else       out_q <= out_d;
    end

    assign bus.out = out_q;
endmodule

// File: tb/tb_mac_unit.sv
// Bench for mac_unit: default width plus narrow (6) and wide (10) result variants.
module tb_mac_unit;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [3:0] a_tb = '0, b_tb = '0, c_tb = '0;

    always #5 clk = ~clk;

    mac_unit_if #(.DATA_WIDTH(4), .OUT_WIDTH(8))  if8();
    mac_unit_if #(.DATA_WIDTH(4), .OUT_WIDTH(6))  if6();
    mac_unit_if #(.DATA_WIDTH(4), .OUT_WIDTH(10)) if10();

    assign if8.a  = a_tb; assign if8.b  = b_tb; assign if8.c  = c_tb;
    assign if6.a  = a_tb; assign if6.b  = b_tb; assign if6.c  = c_tb;
    assign if10.a = a_tb; assign if10.b = b_tb; assign if10.c = c_tb;

    mac_unit #(.DATA_WIDTH(4), .OUT_WIDTH(8))  u8  (.clk(clk), .reset(reset), .bus(if8.slave));
    mac_unit #(.DATA_WIDTH(4), .OUT_WIDTH(6))  u6  (.clk(clk), .reset(reset), .bus(if6.slave));
    mac_unit #(.DATA_WIDTH(4), .OUT_WIDTH(10)) u10 (.clk(clk), .reset(reset), .bus(if10.slave));

    typedef struct {
        logic       rst;
        logic [3:0] a, b, c;
        logic [7:0] e8;
        logic [5:0] e6;
        logic [9:0] e10;
    } vec_t;

    typedef struct {
        logic [7:0] e8;
        logic [5:0] e6;
        logic [9:0] e10;
        string      name;
    } exp_t;

    exp_t sb[$];
    vec_t vecs[12];
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one operand set at the falling edge, queue its expectation, and
    // compare once the following rising edge has registered it.
    task automatic step(input logic rst, input logic [3:0] a, input logic [3:0] b,
                        input logic [3:0] c, input logic [7:0] e8, input logic [5:0] e6,
                        input logic [9:0] e10, input string name);
        exp_t e;
        @(negedge clk);
        reset = rst; a_tb = a; b_tb = b; c_tb = c;
        e.e8 = e8; e.e6 = e6; e.e10 = e10; e.name = name;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: scoreboard empty, got nothing expected one entry", name);
        end else begin
            e = sb.pop_front();
            check({e.name, " out8"},  int'(if8.out),  int'(e.e8));
            check({e.name, " out6"},  int'(if6.out),  int'(e.e6));
            check({e.name, " out10"}, int'(if10.out), int'(e.e10));
        end
    endtask

    initial begin
        logic [7:0] hold8;
        int full;
        logic [3:0] ra, rb, rc;

        vecs[0]  = '{1'b1, 4'd15, 4'd15, 4'd15, 8'h00, 6'h00, 10'h000};
        vecs[1]  = '{1'b1, 4'd15, 4'd15, 4'd15, 8'h00, 6'h00, 10'h000};
        vecs[2]  = '{1'b0, 4'd15, 4'd15, 4'd15, 8'hF0, 6'h30, 10'h0F0};
        vecs[3]  = '{1'b0, 4'd3,  4'd5,  4'd7,  8'h16, 6'h16, 10'h016};
        vecs[4]  = '{1'b0, 4'd9,  4'd7,  4'd4,  8'h43, 6'h03, 10'h043};
        vecs[5]  = '{1'b0, 4'd13, 4'd9,  4'd5,  8'h7A, 6'h3A, 10'h07A};
        vecs[6]  = '{1'b0, 4'd0,  4'd0,  4'd0,  8'h00, 6'h00, 10'h000};
        vecs[7]  = '{1'b0, 4'd3,  4'd5,  4'd7,  8'h16, 6'h16, 10'h016};
        vecs[8]  = '{1'b1, 4'd3,  4'd5,  4'd7,  8'h00, 6'h00, 10'h000};
        vecs[9]  = '{1'b0, 4'd3,  4'd5,  4'd7,  8'h16, 6'h16, 10'h016};
        vecs[10] = '{1'b0, 4'd15, 4'd1,  4'd0,  8'h0F, 6'h0F, 10'h00F};
        vecs[11] = '{1'b0, 4'd1,  4'd1,  4'd15, 8'h10, 6'h10, 10'h010};

        for (int i = 0; i < 12; i++)
            step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c,
                 vecs[i].e8, vecs[i].e6, vecs[i].e10, $sformatf("vec%0d", i));

        // Output must hold between edges: change operands mid-cycle and look again.
        hold8 = 8'h10;
        @(negedge clk);
        a_tb = 4'd15; b_tb = 4'd15; c_tb = 4'd15;
        #2;
        check("hold_between_edges", int'(if8.out), int'(hold8));

        // Random stream against a reference model.
        for (int i = 0; i < 24; i++) begin
            ra = 4'($urandom_range(0, 15));
            rb = 4'($urandom_range(0, 15));
            rc = 4'($urandom_range(0, 15));
            full = int'(ra) * int'(rb) + int'(rc);
            step(1'b0, ra, rb, rc, 8'(full), 6'(full), 10'(full), $sformatf("rand%0d", i));
        end

        // Reset wins over operands, and the stream resumes one edge after release.
        step(1'b1, 4'd15, 4'd15, 4'd15, 8'h00, 6'h00, 10'h000, "late_reset");
        step(1'b0, 4'd9,  4'd7,  4'd4,  8'h43, 6'h03, 10'h043, "after_late_reset");

        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
